// File: rtl/cpu_io_port.sv
// CPU-side I/O port shell: NPORTS direction/data register pairs decoded from the core address,
// with capacitive retention of floating input bits after an output is released.
module cpu_io_port #(
    parameter int                WIDTH       = 8,
    parameter int                NPORTS      = 1,
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h0000,
    parameter logic [WIDTH-1:0]  FADE_MASK   = 8'hC0,
    parameter int                FADE_CYCLES = 350000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     aec,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic                     cpu_we,
    input  logic [WIDTH-1:0]         cpu_dout,
    input  logic [NPORTS*WIDTH-1:0]  port_in,
    output logic                     hit,
    output logic [WIDTH-1:0]         rdata,
    output logic [NPORTS*WIDTH-1:0]  port_out,
    output logic [NPORTS*WIDTH-1:0]  port_dir,
    output logic                     bus_rw,
    output logic [NPORTS-1:0]        fade_busy
);

    localparam int CNT_W = (FADE_CYCLES == 0) ? 1 : $clog2(FADE_CYCLES + 1);
    localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [ADDR_W-1:0] WIN_SIZE = ADDR_W'(2 * NPORTS);

    logic [WIDTH-1:0] r_dir  [NPORTS];
    logic [WIDTH-1:0] r_data [NPORTS];
    logic [WIDTH-1:0] r_ret  [NPORTS];
    logic [CNT_W-1:0] r_cnt  [NPORTS][WIDTH];

    logic [ADDR_W-1:0] w_offset;
    logic              w_sel_data;
    logic              w_wr;
    logic [WIDTH-1:0]  w_dir_nxt  [NPORTS];
    logic [WIDTH-1:0]  w_data_nxt [NPORTS];
    logic [WIDTH-1:0]  w_busy     [NPORTS];
    logic [WIDTH-1:0]  w_pin_eff  [NPORTS];
    logic [NPORTS-1:0] w_sel;
    logic [NPORTS-1:0] w_abort;

    assign w_offset   = cpu_addr - BASE_ADDR;
    assign hit        = (w_offset < WIN_SIZE);
    assign w_sel_data = w_offset[0];
    assign w_wr       = enable & cpu_we & hit;
    assign bus_rw     = ~aec | ~cpu_we | hit;

    always_comb begin
        for (int k = 0; k < NPORTS; k++) begin
            w_sel[k]      = hit && (w_offset[IDX_W:1] == IDX_W'(k));
            w_dir_nxt[k]  = r_dir[k];
            w_data_nxt[k] = r_data[k];
            if (w_wr && w_sel[k] && !w_sel_data) w_dir_nxt[k]  = cpu_dout;
            if (w_wr && w_sel[k] &&  w_sel_data) w_data_nxt[k] = cpu_dout;
            for (int b = 0; b < WIDTH; b++) begin
                w_busy[k][b]    = (r_cnt[k][b] != '0);
                w_pin_eff[k][b] = (FADE_MASK[b] && w_busy[k][b]) ? r_ret[k][b]
                                                                 : port_in[k*WIDTH + b];
            end
            // Re-driving any still-fading bit aborts the whole port's fade.
            w_abort[k]  = w_wr && w_sel[k] && !w_sel_data
                          && |(~r_dir[k] & w_dir_nxt[k] & w_busy[k] & FADE_MASK);
            fade_busy[k]                  = |w_busy[k];
            port_out[k*WIDTH +: WIDTH]    = r_data[k];
            port_dir[k*WIDTH +: WIDTH]    = r_dir[k];
        end
    end

    always_comb begin
        rdata = {WIDTH{1'b1}};
        for (int k = 0; k < NPORTS; k++) begin
            if (w_sel[k]) begin
                rdata = w_sel_data ? ((r_dir[k] & r_data[k]) | (~r_dir[k] & w_pin_eff[k]))
                                   : r_dir[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NPORTS; k++) begin
                r_dir[k]  <= '0;
                r_data[k] <= '0;
                r_ret[k]  <= '0;
                for (int b = 0; b < WIDTH; b++) r_cnt[k][b] <= '0;
            end
        end else if (enable) begin
            for (int k = 0; k < NPORTS; k++) begin
                r_dir[k]  <= w_dir_nxt[k];
                r_data[k] <= w_data_nxt[k];
                for (int b = 0; b < WIDTH; b++) begin
                    if (FADE_MASK[b]) begin
                        if (w_dir_nxt[k][b]) begin
                            r_ret[k][b] <= w_data_nxt[k][b];
                            r_cnt[k][b] <= '0;
                        end else if (r_dir[k][b]) begin
                            r_ret[k][b] <= r_data[k][b];
                            r_cnt[k][b] <= CNT_W'(FADE_CYCLES);
                        end else if (w_abort[k]) begin
                            r_ret[k][b] <= 1'b0;
                            r_cnt[k][b] <= '0;
                        end else if (w_busy[k][b]) begin
                            r_cnt[k][b] <= r_cnt[k][b] - 1'b1;
                            if (r_cnt[k][b] == CNT_W'(1)) r_ret[k][b] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_io_port.sv
// Bench for cpu_io_port: a single-port instance at $0000 and a two-port instance at $FF00,
// both with a short fade time, driven from a vector table plus hand-written fade/reset sequences.
module tb_cpu_io_port;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        aec;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_dout;
    logic [7:0]  pin0;
    logic [15:0] pin1;

    logic        hit0, brw0, hit1, brw1;
    logic [7:0]  rd0, rd1;
    logic [7:0]  pout0, pdir0;
    logic [15:0] pout1, pdir1;
    logic [0:0]  busy0;
    logic [1:0]  busy1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_io_port #(.WIDTH(8), .NPORTS(1), .ADDR_W(16), .BASE_ADDR(16'h0000),
                  .FADE_MASK(8'hC0), .FADE_CYCLES(4)) u0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .aec(aec),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_dout(cpu_dout), .port_in(pin0),
        .hit(hit0), .rdata(rd0), .port_out(pout0), .port_dir(pdir0),
        .bus_rw(brw0), .fade_busy(busy0));

    cpu_io_port #(.WIDTH(8), .NPORTS(2), .ADDR_W(16), .BASE_ADDR(16'hFF00),
                  .FADE_MASK(8'hC0), .FADE_CYCLES(4)) u1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .aec(aec),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_dout(cpu_dout), .port_in(pin1),
        .hit(hit1), .rdata(rd1), .port_out(pout1), .port_dir(pdir1),
        .bus_rw(brw1), .fade_busy(busy1));

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic        en;
        logic [7:0]  dout;
        logic [7:0]  pin;
        logic [7:0]  rdata;
        logic        hit;
        logic        brw;
        logic [7:0]  pout;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        enable   = 1'b1;
        cpu_addr = a;
        cpu_dout = d;
        cpu_we   = 1'b1;
        @(negedge clk);
        cpu_we   = 1'b0;
    endtask

    task automatic step(input logic en);
        enable = en;
        cpu_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_u0(input logic [15:0] a, input string name, input logic [7:0] exp_rd,
                         input logic exp_busy);
        cpu_addr = a;
        cpu_we   = 1'b0;
        #1;
        chk({name, "_rdata"}, 32'(rd0), 32'(exp_rd));
        chk({name, "_busy"}, 32'(busy0), 32'(exp_busy));
    endtask

    initial begin
        //      addr      we    en    dout   pin    rdata  hit   brw   pout
        vt[0]  = '{16'h0000, 1'b0, 1'b1, 8'h00, 8'hA5, 8'h00, 1'b1, 1'b1, 8'h00};
        vt[1]  = '{16'h0001, 1'b0, 1'b1, 8'h00, 8'hA5, 8'hA5, 1'b1, 1'b1, 8'h00};
        vt[2]  = '{16'h0000, 1'b1, 1'b1, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b1, 8'h00};
        vt[3]  = '{16'h0001, 1'b1, 1'b1, 8'h3C, 8'hF0, 8'hF0, 1'b1, 1'b1, 8'h00};
        vt[4]  = '{16'h0001, 1'b0, 1'b1, 8'h00, 8'hF0, 8'hFC, 1'b1, 1'b1, 8'h3C};
        vt[5]  = '{16'h0001, 1'b0, 1'b1, 8'h00, 8'h00, 8'h0C, 1'b1, 1'b1, 8'h3C};
        vt[6]  = '{16'h0002, 1'b1, 1'b1, 8'h77, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h3C};
        vt[7]  = '{16'h0002, 1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 8'h3C};
        vt[8]  = '{16'hFFFF, 1'b1, 1'b1, 8'h77, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h3C};
        vt[9]  = '{16'h0000, 1'b0, 1'b1, 8'h00, 8'h00, 8'h0F, 1'b1, 1'b1, 8'h3C};
        vt[10] = '{16'h0001, 1'b1, 1'b0, 8'hAA, 8'h00, 8'h0C, 1'b1, 1'b1, 8'h3C};
        vt[11] = '{16'h0001, 1'b0, 1'b1, 8'h00, 8'h00, 8'h0C, 1'b1, 1'b1, 8'h3C};

        reset_n  = 1'b0;
        enable   = 1'b0;
        aec      = 1'b1;
        cpu_addr = 16'h0000;
        cpu_we   = 1'b0;
        cpu_dout = 8'h00;
        pin0     = 8'hA5;
        pin1     = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pout", 32'(pout0), 32'h00);
        chk("rst_pdir", 32'(pdir0), 32'h00);
        chk("rst_busy", 32'(busy0), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            cpu_addr = vt[i].addr;
            cpu_we   = vt[i].we;
            enable   = vt[i].en;
            cpu_dout = vt[i].dout;
            pin0     = vt[i].pin;
            #1;
            chk($sformatf("vec%0d_rdata", i), 32'(rd0), 32'(vt[i].rdata));
            chk($sformatf("vec%0d_hit", i), 32'(hit0), 32'(vt[i].hit));
            chk($sformatf("vec%0d_busrw", i), 32'(brw0), 32'(vt[i].brw));
            chk($sformatf("vec%0d_pout", i), 32'(pout0), 32'(vt[i].pout));
            @(negedge clk);
        end

        // Fade: drive bits 7:6 high, release them, pins held low.
        pin0 = 8'h00;
        wr(16'h0000, 8'hC0);
        wr(16'h0001, 8'hC0);
        rd_u0(16'h0001, "driven", 8'hC0, 1'b0);
        wr(16'h0000, 8'h00);
        enable = 1'b0;
        rd_u0(16'h0001, "fade_t1", 8'hC0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0);
        rd_u0(16'h0001, "fade_idle", 8'hC0, 1'b1);
        for (int i = 2; i <= 4; i++) begin
            step(1'b1);
            rd_u0(16'h0001, $sformatf("fade_t%0d", i), 8'hC0, 1'b1);
        end
        step(1'b1);
        rd_u0(16'h0001, "fade_t5", 8'h00, 1'b0);
        chk("fade_pout", 32'(pout0), 32'hC0);

        // Abort: re-drive bit7 mid-fade.
        wr(16'h0000, 8'hC0);
        wr(16'h0000, 8'h00);
        rd_u0(16'h0001, "abort_pre", 8'hC0, 1'b1);
        step(1'b1);
        rd_u0(16'h0001, "abort_mid", 8'hC0, 1'b1);
        wr(16'h0000, 8'h80);
        rd_u0(16'h0001, "abort_post", 8'h80, 1'b0);
        pin0 = 8'h40;
        rd_u0(16'h0001, "abort_pin", 8'hC0, 1'b0);
        pin0 = 8'h00;

        // Async reset while bit7 is fading.
        wr(16'h0000, 8'h00);
        rd_u0(16'h0001, "prerst", 8'h80, 1'b1);
        reset_n = 1'b0;
        #2;
        chk("arst_busy", 32'(busy0), 32'h0);
        chk("arst_pout", 32'(pout0), 32'h00);
        chk("arst_pdir", 32'(pdir0), 32'h00);
        chk("arst_rdata", 32'(rd0), 32'h00);
        #1;
        reset_n = 1'b1;
        @(negedge clk);

        // Two-port instance at $FF00.
        wr(16'hFF02, 8'hFF);
        wr(16'hFF03, 8'h55);
        #1;
        chk("mp_pout", 32'(pout1), 32'h5500);
        chk("mp_pdir", 32'(pdir1), 32'hFF00);
        cpu_addr = 16'hFF03;
        #1;
        chk("mp_rd_ff03", 32'(rd1), 32'h55);
        chk("mp_hit_ff03", 32'(hit1), 32'h1);
        pin1 = 16'h00A5;
        cpu_addr = 16'hFF01;
        #1;
        chk("mp_rd_ff01", 32'(rd1), 32'hA5);
        cpu_addr = 16'hFF00;
        #1;
        chk("mp_rd_ff00", 32'(rd1), 32'h00);
        enable = 1'b0;
        cpu_addr = 16'hFF04;
        cpu_we = 1'b1;
        #1;
        chk("mp_hit_ff04", 32'(hit1), 32'h0);
        chk("mp_rd_ff04", 32'(rd1), 32'hFF);
        chk("mp_brw_we1", 32'(brw1), 32'h0);
        cpu_we = 1'b0;
        #1;
        chk("mp_brw_we0", 32'(brw1), 32'h1);
        cpu_we = 1'b1;
        aec = 1'b0;
        #1;
        chk("mp_brw_aec0", 32'(brw1), 32'h1);
        cpu_addr = 16'hFEFF;
        #1;
        chk("mp_hit_feff", 32'(hit1), 32'h0);
        cpu_addr = 16'hFF03;
        #1;
        chk("mp_hit_aec0", 32'(hit1), 32'h1);
        cpu_we = 1'b0;
        aec = 1'b1;
        @(negedge clk);
        chk("mp_pout_hold", 32'(pout1), 32'h5500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_io_port.md
Name: cpu_io_port

Overview:
- Parametrised on-chip CPU I/O port shell, the successor to the fixed single 8-bit port at $0000/$0001.
- Sits between the CPU core and the system bus.
- Decodes NPORTS direction/data register pairs, provides read-back data and external port pins, and suppresses external bus writes for port hits.
- New behaviour: capacitive retention ("fade") of selected floating input bits after a pin is switched from output to input, as on real 6510/8501 silicon.

Parameters:
WIDTH, 8, bits per port
NPORTS, 1, number of dir/data register pairs (1..4)
ADDR_W, 16, CPU address width
BASE_ADDR, 16'h0000, address of port 0 direction register; port k: dir at BASE_ADDR+2k, data at BASE_ADDR+2k+1
FADE_MASK, 8'hC0, WIDTH-bit mask of bits with retention emulation (applies to every port)
FADE_CYCLES, 350000, enable ticks a retained bit persists; 0 disables fade

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  CPU clock enable; all register updates qualified by it
aec  in  1  CPU owns bus; 0 = bus released to video
cpu_addr  in  ADDR_W  core address
cpu_we  in  1  core write strobe, 1 = write
cpu_dout  in  WIDTH  core write data
port_in  in  NPORTS*WIDTH  external pin levels, port k at [k*WIDTH +: WIDTH]
hit  out  1  cpu_addr inside the port window (combinational)
rdata  out  WIDTH  port read-back, valid when hit (combinational)
port_out  out  NPORTS*WIDTH  data registers
port_dir  out  NPORTS*WIDTH  direction registers, 1 = output
bus_rw  out  1  external R/W: ~aec | ~cpu_we | hit
fade_busy  out  NPORTS  port k has at least one nonzero fade counter

Behaviour:
- Reset (async, reset_n=0): all dir, data, retained and fade counters = 0. Outputs: port_out=0, port_dir=0, fade_busy=0. Combinational outputs follow their inputs.
- Decode:
  - hit = cpu_addr in [BASE_ADDR, BASE_ADDR+2*NPORTS-1].
  - Index k = (cpu_addr-BASE_ADDR)>>1; the LSB of the offset selects data(1)/dir(0).
  - Decode is independent of aec.
- Write: on posedge clk with enable & cpu_we & hit, update the selected register with cpu_dout. Takes effect the next cycle. No write without enable.
- Read:
  - dir address: rdata = dir[k].
  - data address: rdata = (dir & data) | (~dir & pin_eff), combinational, zero latency.
  - Not hit: rdata = {WIDTH{1'b1}}.
- pin_eff per bit b:
  - b in FADE_MASK and counter[k][b] != 0: pin_eff = retained[k][b].
  - otherwise: pin_eff = port_in bit.
- Retention, per port and per masked bit, evaluated each enable tick using post-write register values:
  - dir bit = 1: retained <= data bit; counter <= 0.
  - dir bit 1->0 in this tick: retained <= old data bit; counter <= FADE_CYCLES.
  - dir bit = 0, counter > 0: counter decrements by 1. At 1->0 pin_eff reverts to port_in; retained is cleared to 0.
  - Simultaneous data write and dir 1->0 in one tick: impossible (single address); sequential writes apply in order.
  - Data write while dir = 0: data updates, retained unchanged, counter unchanged.
  - dir 0->1 while counter > 0: counter cleared immediately; bit becomes output.
  - FADE_CYCLES = 0: counters never load; pure port_in behaviour, identical to the legacy port.
  - Counter width = clog2(FADE_CYCLES+1), minimum 1. Counters saturate at 0 and never wrap.
- fade_busy[k] = OR of port k counters, registered with the counters.
- bus_rw = 1 for any port hit, so external memory never sees a write to the port window. Also 1 whenever aec = 0.
- Mid-operation reset clears counters; retention is lost immediately.

Test Plan:
- Reset then read: after reset_n deassert, read $0000 -> 8'h00; read $0001 with port_in=8'hA5 -> 8'hA5; port_out=0, bus_rw=1.
- Write and readback: write dir $0000=8'h0F, data $0001=8'h3C, port_in=8'hF0 -> rdata at $0001 = 8'hFC; port_out=8'h3C; bus_rw=1 during the write cycle.
- Fade, FADE_CYCLES=4: dir=8'hC0, data=8'hC0, port_in=8'h00, then dir=8'h00.
  - Reads of $0001 return 8'hC0 for 4 enable ticks; fade_busy=1.
  - On the 5th tick the read returns 8'h00 and fade_busy=0.
  - Idle clocks with enable=0 do not advance the count.
- Fade abort: during fade, write dir=8'h80 -> bit7 driven from data, bit6 immediately reads port_in, fade_busy=0 next cycle.
- Multi-port, NPORTS=2, BASE_ADDR=16'hFF00: write $FF02=8'hFF, $FF03=8'h55 -> port_out[15:8]=8'h55, port 0 untouched; $FF04 not hit, bus_rw follows cpu_we; aec=0 forces bus_rw=1.
- Async reset mid-fade: assert reset_n=0 with counters nonzero -> all registers and fade_busy cleared without a clock edge.
